otter_dmem_arbiter: RTL and testbench
=====================================

// Module: otter_dmem_arbiter
// PURPOSE
//  Shares the data port of OTTER_mem_byte (MEM_ADDR2/DIN2/WRITE2/READ2/SIZE/SIGN/DOUT2) between
//  port 0 (pipelined CPU MEM stage) and port 1 (debug/DMA bus master). Issues at most one access
//  per cycle, routes the 1-cycle-latency read data back to the owner, and bounds port-1 starvation.
//  Port 0 uses !P0_GNT while P0_REQ=1 as its MEM-stage stall.
// PARAMETERS
//  MAX_WAIT  8  cycles P1 may be denied while requesting before a forced P1 grant; legal range >=1
// PORTS
//  CLK                  in   1   clock, rising edge
//  RESET_N              in   1   asynchronous, active-low reset
//  P0_REQ, P1_REQ       in   1   access request; held with its fields stable until GNT seen
//  P0_WE, P1_WE         in   1   1=write, 0=read
//  P0_ADDR, P1_ADDR     in   32  byte address
//  P0_WDATA, P1_WDATA   in   32  store data
//  P0_SIZE, P1_SIZE     in   2   00=byte 01=half 10=word
//  P0_SIGN, P1_SIGN     in   1   1=zero-extend load (memType[2] encoding)
//  P0_GNT, P1_GNT       out  1   access issued to memory this cycle (REQ & GNT = transfer)
//  P0_RVALID, P1_RVALID out  1   read data valid this cycle (read granted previous cycle)
//  P0_RDATA, P1_RDATA   out  32  MEM_DOUT2 pass-through; meaningful only with RVALID
//  MEM_ADDR2            out  32  winner address; P0_ADDR when idle
//  MEM_DIN2             out  32  winner WDATA; P0_WDATA when idle
//  MEM_WRITE2           out  1   winner REQ & WE
//  MEM_READ2            out  1   winner REQ & !WE
//  MEM_SIZE, MEM_SIGN   out  2,1 winner SIZE/SIGN; P0 values when idle
//  MEM_DOUT2            in   32  synchronous read data, valid cycle after MEM_READ2
// BEHAVIOUR
//  - Reset (RESET_N=0, async): GNT=0 both, RVALID=0 both, MEM_WRITE2=MEM_READ2=0, wait_cnt=0,
//    last_gnt=1, rd_owner_valid=0. All GNT/strobe outputs are gated low while RESET_N=0.
//  - Arbitration is combinational per cycle from REQs + registered state; 0-cycle grant latency.
//    Exactly one of P0_GNT/P1_GNT high when any REQ high; both low when no REQ.
//  - Fixed priority (default): P0 wins ties, unless wait_cnt==MAX_WAIT -> P1 wins.
//  - wait_cnt (width $clog2(MAX_WAIT+1)): +1 each cycle P1_REQ & !P1_GNT, saturating at MAX_WAIT;
//    cleared on P1 grant or when P1_REQ=0.
//  - Single requester always granted immediately regardless of wait_cnt/last_gnt.
//  - last_gnt <= index of granted port on every grant; held when idle.
//  - Read return: on granted read, register rd_owner; next cycle RVALID of that port = 1 for exactly
//    one cycle, RDATA = MEM_DOUT2. Back-to-back reads (any ports) fully pipelined, 1 access/cycle.
//  - Writes complete on the grant cycle; no RVALID.
//  - Reset asserted between a granted read and its return: RVALID suppressed; read discarded.
//  - Request withdrawn without GNT: legal, no side effect. Fields changing while REQ & !GNT: illegal.
//  - No address decode, no error reporting; IO range handled downstream by OTTER_mem_byte.
// CONFIGURATION
//  OTTER_DMEM_ARB_RR_EN defined: round-robin; on tie the port != last_gnt wins; wait_cnt and
//   MAX_WAIT unused (counter not instantiated). Single-requester behaviour unchanged.
//  Undefined: fixed priority P0 with MAX_WAIT starvation guard as above.
// TESTING
//  1 RESET_N=0 with P0_REQ=P1_REQ=1 -> GNTs=0, RVALIDs=0, MEM_WRITE2=MEM_READ2=0 throughout.
//  2 P0 read 0x0000_0100, word, P1 idle -> cycle t: P0_GNT=1, MEM_READ2=1, MEM_ADDR2=0x100;
//    t+1: P0_RVALID=1, P0_RDATA=MEM_DOUT2, P1_RVALID=0.
//  3 P1 write 0xDEADBEEF to 0x1100_0040, byte, P0 idle -> P1_GNT=1, MEM_WRITE2=1,
//    MEM_DIN2=0xDEADBEEF, MEM_SIZE=00; no RVALID next cycle.
//  4 Fixed mode, MAX_WAIT=8, both REQ held -> P0 granted 8 cycles, P1 granted cycle 9, P0 cycle 10.
//  5 Granted P0 read at t, RESET_N=0 at t+0.5 cycle -> P0_RVALID=0 at t+1; post-reset grants clean.
//  6 OTTER_DMEM_ARB_RR_EN, both REQ held from reset -> grants P0,P1,P0,P1...; P0+P1 reads
//    alternate with RVALID alternating one cycle later, each RDATA matching its own address.

Source files
------------

// File: rtl/otter_dmem_arbiter.sv
// Two-port arbiter for the OTTER_mem_byte data port. Port 0 is the CPU MEM stage and port 1 is the debug/DMA master.
// Define OTTER_DMEM_ARB_RR_EN for round-robin; otherwise P0 has fixed priority and MAX_WAIT bounds P1 starvation.
module otter_dmem_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        P0_REQ,
    input  logic        P0_WE,
    input  logic [31:0] P0_ADDR,
    input  logic [31:0] P0_WDATA,
    input  logic [1:0]  P0_SIZE,
    input  logic        P0_SIGN,
    output logic        P0_GNT,
    output logic        P0_RVALID,
    output logic [31:0] P0_RDATA,
    input  logic        P1_REQ,
    input  logic        P1_WE,
    input  logic [31:0] P1_ADDR,
    input  logic [31:0] P1_WDATA,
    input  logic [1:0]  P1_SIZE,
    input  logic        P1_SIGN,
    output logic        P1_GNT,
    output logic        P1_RVALID,
    output logic [31:0] P1_RDATA,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    logic selP1;
    logic anyReq;
    logic winWe;
    logic tieP1;
    logic rdOwnerValid;
    logic rdOwner;

`ifdef OTTER_DMEM_ARB_RR_EN
    logic lastGnt;

    assign tieP1 = ~lastGnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lastGnt <= 1'b1;
        end else if (anyReq) begin
            lastGnt <= selP1;
        end
    end
`else
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] waitCnt;

    assign tieP1 = (waitCnt == WAIT_MAX);

    // Counts consecutive denied P1 cycles; any gap in P1_REQ restarts the window.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            waitCnt <= '0;
        end else if (!P1_REQ || P1_GNT) begin
            waitCnt <= '0;
        end else if (waitCnt != WAIT_MAX) begin
            waitCnt <= waitCnt + CW'(1);
        end
    end
`endif

    always_comb begin
        selP1 = 1'b0;
        if (P1_REQ && !P0_REQ) begin
            selP1 = 1'b1;
        end else if (P1_REQ && P0_REQ) begin
            selP1 = tieP1;
        end
    end

    // Reset gates every grant and strobe so nothing reaches memory while RESET_N is low.
    assign anyReq = RESET_N & (P0_REQ | P1_REQ);
    assign P0_GNT = anyReq & ~selP1;
    assign P1_GNT = anyReq & selP1;

    assign winWe      = selP1 ? P1_WE : P0_WE;
    assign MEM_ADDR2  = selP1 ? P1_ADDR : P0_ADDR;
    assign MEM_DIN2   = selP1 ? P1_WDATA : P0_WDATA;
    assign MEM_SIZE   = selP1 ? P1_SIZE : P0_SIZE;
    assign MEM_SIGN   = selP1 ? P1_SIGN : P0_SIGN;
    assign MEM_WRITE2 = anyReq & winWe;
    assign MEM_READ2  = anyReq & ~winWe;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdOwnerValid <= 1'b0;
            rdOwner      <= 1'b0;
        end else begin
            rdOwnerValid <= MEM_READ2;
            if (MEM_READ2) begin
                rdOwner <= selP1;
            end
        end
    end

    assign P0_RVALID = rdOwnerValid & ~rdOwner;
    assign P1_RVALID = rdOwnerValid & rdOwner;
    assign P0_RDATA  = MEM_DOUT2;
    assign P1_RDATA  = MEM_DOUT2;

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Bench for otter_dmem_arbiter: directed cases plus random traffic against a transaction-level model.
// The model follows OTTER_DMEM_ARB_RR_EN the same way the design does.
module tb_otter_dmem_arbiter;
    localparam int MAX_WAIT = 8;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        P0_REQ = 1'b0, P0_WE = 1'b0, P0_SIGN = 1'b0;
    logic [31:0] P0_ADDR = '0, P0_WDATA = '0;
    logic [1:0]  P0_SIZE = '0;
    logic        P1_REQ = 1'b0, P1_WE = 1'b0, P1_SIGN = 1'b0;
    logic [31:0] P1_ADDR = '0, P1_WDATA = '0;
    logic [1:0]  P1_SIZE = '0;
    logic        P0_GNT, P0_RVALID, P1_GNT, P1_RVALID;
    logic [31:0] P0_RDATA, P1_RDATA;
    logic [31:0] MEM_ADDR2, MEM_DIN2;
    logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
    logic [1:0]  MEM_SIZE;
    logic [31:0] MEM_DOUT2 = '0;

    int nCompared = 0;
    int nMismatch = 0;

    int          mWaited;
    int          mLast;
    int          mWin;
    bit          mPend;
    int          mPendPort;
    logic [31:0] mPendAddr;

    otter_dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA),
        .P0_SIZE(P0_SIZE), .P0_SIGN(P0_SIGN), .P0_GNT(P0_GNT), .P0_RVALID(P0_RVALID),
        .P0_RDATA(P0_RDATA),
        .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA),
        .P1_SIZE(P1_SIZE), .P1_SIGN(P1_SIGN), .P1_GNT(P1_GNT), .P1_RVALID(P1_RVALID),
        .P1_RDATA(P1_RDATA),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
        .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    // Synchronous memory stand-in: data for a read appears the cycle after MEM_READ2.
    always @(posedge CLK) begin
        if (MEM_READ2) MEM_DOUT2 <= memFn(MEM_ADDR2);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mWaited = 0;
        mLast   = 1;
        mPend   = 1'b0;
        mWin    = -1;
    endtask

    // Called mid-cycle with inputs settled: checks outputs, then advances the model past the next edge.
    task automatic stepCheck();
        logic wWe;
        if (!P0_REQ && !P1_REQ) mWin = -1;
        else if (!P1_REQ) mWin = 0;
        else if (!P0_REQ) mWin = 1;
        else begin
`ifdef OTTER_DMEM_ARB_RR_EN
            mWin = (mLast == 0) ? 1 : 0;
`else
            mWin = (mWaited >= MAX_WAIT) ? 1 : 0;
`endif
        end
        wWe = (mWin == 1) ? P1_WE : P0_WE;
        checkVal("p0_gnt", 32'(P0_GNT), 32'(mWin == 0));
        checkVal("p1_gnt", 32'(P1_GNT), 32'(mWin == 1));
        checkVal("mem_write", 32'(MEM_WRITE2), 32'(mWin >= 0 && wWe));
        checkVal("mem_read", 32'(MEM_READ2), 32'(mWin >= 0 && !wWe));
        checkVal("mem_addr", MEM_ADDR2, (mWin == 1) ? P1_ADDR : P0_ADDR);
        checkVal("mem_din", MEM_DIN2, (mWin == 1) ? P1_WDATA : P0_WDATA);
        checkVal("mem_size", 32'(MEM_SIZE), 32'((mWin == 1) ? P1_SIZE : P0_SIZE));
        checkVal("mem_sign", 32'(MEM_SIGN), 32'((mWin == 1) ? P1_SIGN : P0_SIGN));
        checkVal("p0_rvalid", 32'(P0_RVALID), 32'(mPend && mPendPort == 0));
        checkVal("p1_rvalid", 32'(P1_RVALID), 32'(mPend && mPendPort == 1));
        if (mPend) begin
            checkVal("rdata", (mPendPort == 0) ? P0_RDATA : P1_RDATA, memFn(mPendAddr));
        end
        mPend     = (mWin >= 0) && !wWe;
        mPendPort = mWin;
        mPendAddr = (mWin == 1) ? P1_ADDR : P0_ADDR;
        if (P1_REQ && mWin != 1) mWaited = (mWaited < MAX_WAIT) ? mWaited + 1 : MAX_WAIT;
        else mWaited = 0;
        if (mWin >= 0) mLast = mWin;
    endtask

    task automatic idleBoth();
        P0_REQ = 1'b0;
        P1_REQ = 1'b0;
    endtask

    initial begin
        modelReset();

        // Reset with both ports requesting: nothing may be granted or strobed.
        P0_REQ = 1'b1; P1_REQ = 1'b1; P0_WE = 1'b1; P1_WE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            checkVal("rst_p0_gnt", 32'(P0_GNT), 0);
            checkVal("rst_p1_gnt", 32'(P1_GNT), 0);
            checkVal("rst_rvalid", 32'({P0_RVALID, P1_RVALID}), 0);
            checkVal("rst_strobes", 32'({MEM_WRITE2, MEM_READ2}), 0);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        idleBoth();
        modelReset();
        #1 stepCheck();

        // P0 word read, P1 idle.
        @(negedge CLK);
        P0_REQ = 1'b1; P0_WE = 1'b0; P0_ADDR = 32'h0000_0100; P0_SIZE = 2'b10; P0_SIGN = 1'b0;
        #1;
        checkVal("t2_addr", MEM_ADDR2, 32'h0000_0100);
        stepCheck();
        @(negedge CLK); idleBoth(); #1;
        checkVal("t2_rdata", P0_RDATA, memFn(32'h0000_0100));
        stepCheck();

        // P1 byte write, P0 idle.
        @(negedge CLK);
        P1_REQ = 1'b1; P1_WE = 1'b1; P1_ADDR = 32'h1100_0040; P1_WDATA = 32'hDEAD_BEEF;
        P1_SIZE = 2'b00; P1_SIGN = 1'b0;
        #1;
        checkVal("t3_din", MEM_DIN2, 32'hDEAD_BEEF);
        stepCheck();
        @(negedge CLK); idleBoth(); #1 stepCheck();

        // Both held with reads: starvation guard (fixed) or alternation (round-robin).
        P0_WE = 1'b0; P1_WE = 1'b0; P0_ADDR = 32'h0000_0200; P1_ADDR = 32'h0000_0300;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            P0_REQ = 1'b1; P1_REQ = 1'b1;
            #1;
`ifdef OTTER_DMEM_ARB_RR_EN
            checkVal("t6_p1_gnt", 32'(P1_GNT), 32'(i % 2 == 1));
`else
            checkVal("t4_p1_gnt", 32'(P1_GNT), 32'(i == MAX_WAIT));
`endif
            stepCheck();
        end
        @(negedge CLK); idleBoth(); #1 stepCheck();

        // Reset lands between a granted read and its return.
        @(negedge CLK);
        P0_REQ = 1'b1; P0_WE = 1'b0; P0_ADDR = 32'h0000_0400;
        #1 stepCheck();
        @(negedge CLK);
        RESET_N = 1'b0;
        idleBoth();
        #1;
        checkVal("t5_p0_rvalid", 32'(P0_RVALID), 0);
        checkVal("t5_p1_rvalid", 32'(P1_RVALID), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        modelReset();
        #1 stepCheck();

        // Random traffic; a request that was not granted holds its fields.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (!(P0_REQ && mWin != 0)) begin
                P0_REQ   = ($urandom_range(0, 99) < 60);
                P0_WE    = $urandom_range(0, 1);
                P0_ADDR  = $urandom;
                P0_WDATA = $urandom;
                P0_SIZE  = 2'($urandom_range(0, 2));
                P0_SIGN  = $urandom_range(0, 1);
            end
            if (!(P1_REQ && mWin != 1)) begin
                P1_REQ   = ($urandom_range(0, 99) < 50);
                P1_WE    = $urandom_range(0, 1);
                P1_ADDR  = $urandom;
                P1_WDATA = $urandom;
                P1_SIZE  = 2'($urandom_range(0, 2));
                P1_SIGN  = $urandom_range(0, 1);
            end
            #1 stepCheck();
        end
        @(negedge CLK); idleBoth(); #1 stepCheck();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
